// File: rtl/deadlock_block_detector_pkg.sv
// Shared state encoding, default sizing and helpers for the deadlock block detector.
// Pure declarations: no latency, no backpressure.
package deadlock_mon_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } state_e;

    localparam int DEF_THRESHOLD = 16;
    localparam int DEF_CNT_W     = 16;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/deadlock_block_detector_if.sv
// Stall taps in, block flag/snapshot/event count out, between monitor top and detector.
// Wires only: no latency, no backpressure.
interface deadlock_block_detector_if #(
    parameter int NUM_AXIS = 3,
    parameter int NUM_IDLE = 2,
    parameter int NUM_BLK  = 1,
    parameter int CNT_W    = 16
);
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_IDLE-1:0] inst_idle_sigs;
    logic [NUM_BLK-1:0]  inst_block_sigs;
    logic                block;
    logic                block_pulse;
    logic [NUM_AXIS-1:0] block_axis_snap;
    logic [NUM_BLK-1:0]  block_inst_snap;
    logic [CNT_W-1:0]    block_events;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, block_pulse, block_axis_snap, block_inst_snap, block_events
    );
    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, block_pulse, block_axis_snap, block_inst_snap, block_events
    );
endinterface

// File: rtl/deadlock_block_detector_persist_counter.sv
// Persistence counter and stall-pattern snapshot; strobes thr_o on the edge a stable stall reaches THRESHOLD.
// thr_o is combinational from registered cnt/snap; no backpressure.
module deadlock_persist_counter
    import deadlock_mon_pkg::*;
#(
    parameter int PW        = 4,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    state_i,
    input  logic          stall_i,
    input  logic [PW-1:0] pattern_i,
    output logic [PW-1:0] snap_o,
    output logic          chg_o,
    output logic          thr_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    snap_q, snap_d;

    assign chg_o  = (pattern_i != snap_q);
    assign snap_o = snap_q;
    // A pattern change on the threshold edge is progress, so it suppresses the strobe.
    assign thr_o  = (state_i == SUSPECT) && stall_i && !chg_o && (cnt_q == LAST);

    always_comb begin
        cnt_d  = cnt_q;
        snap_d = snap_q;
        case (state_i)
            RUN: begin
                if (stall_i) begin
                    cnt_d  = CNT_W'(1);
                    snap_d = pattern_i;
                end else begin
                    cnt_d = '0;
                end
            end
            SUSPECT: begin
                if (!stall_i) begin
                    cnt_d = '0;
                end else if (chg_o) begin
                    cnt_d  = CNT_W'(1);
                    snap_d = pattern_i;
                end else if (!thr_o) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BLOCKED: begin
`ifndef DEADLOCK_MON_STICKY_EN
                if (!stall_i || chg_o) cnt_d = '0;
`endif
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

endmodule

// File: rtl/deadlock_block_detector.sv
// Raises block after THRESHOLD cycles of one unchanged stall pattern; DEADLOCK_MON_STICKY_EN makes BLOCKED terminal.
// block is registered, high after edge THRESHOLD of a stable stall; no backpressure, inputs sampled every cycle.
module deadlock_block_detector
    import deadlock_mon_pkg::*;
#(
    parameter int NUM_AXIS  = 3,
    parameter int NUM_IDLE  = 2,
    parameter int NUM_BLK   = 1,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    deadlock_block_detector_if.slave dbg
);
    localparam int PW = NUM_AXIS + NUM_BLK;
    localparam logic [1:0] ST_RUN     = RUN;
    localparam logic [1:0] ST_SUSPECT = SUSPECT;
    localparam logic [1:0] ST_BLOCKED = BLOCKED;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0]       pattern;
    logic [PW-1:0]       snap;
    logic [NUM_IDLE-1:0] idle;
    logic                stall, chg, thr;

    logic [1:0]       state_q, state_d;
    logic             block_q, block_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] events_q, events_d;

    assign pattern = {dbg.axis_block_sigs, dbg.inst_block_sigs};
    assign idle    = dbg.inst_idle_sigs;
    // A fully idle kernel is quiescent, not deadlocked, whatever the stream taps say.
    assign stall   = (|pattern) & ~(&idle);

    deadlock_persist_counter #(
        .PW       (PW),
        .THRESHOLD(THRESHOLD),
        .CNT_W    (CNT_W)
    ) u_persist (
        .clock    (clock),
        .reset    (reset),
        .state_i  (state_q),
        .stall_i  (stall),
        .pattern_i(pattern),
        .snap_o   (snap),
        .chg_o    (chg),
        .thr_o    (thr)
    );

    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        pulse_d  = 1'b0;
        events_d = events_q;
        case (state_q)
            ST_RUN: if (stall) state_d = ST_SUSPECT;
            ST_SUSPECT: begin
                if (!stall) begin
                    state_d = ST_RUN;
                end else if (thr) begin
                    state_d  = ST_BLOCKED;
                    block_d  = 1'b1;
                    pulse_d  = 1'b1;
                    events_d = CNT_W'(sat_inc(32'(events_q), 32'(CNT_MAX)));
                end
            end
            ST_BLOCKED: begin
`ifndef DEADLOCK_MON_STICKY_EN
                if (!stall || chg) begin
                    state_d = ST_RUN;
                    block_d = 1'b0;
                end
`endif
            end
            default: begin
                state_d = ST_RUN;
                block_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            block_q  <= 1'b0;
            pulse_q  <= 1'b0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            block_q  <= block_d;
            pulse_q  <= pulse_d;
            events_q <= events_d;
        end
    end

    assign dbg.block           = block_q;
    assign dbg.block_pulse     = pulse_q;
    assign dbg.block_axis_snap = snap[PW-1:NUM_BLK];
    assign dbg.block_inst_snap = snap[NUM_BLK-1:0];
    assign dbg.block_events    = events_q;

endmodule
